// File: rtl/bus_arbiter_mux.sv
// Round-robin bus arbiter for N masters with active-low request/grant, plus the
// master->slave mux that steers the owner's address, strobe, R/W and write data.
//
// state | meaning
// IDLE  | no grant held, all mGrnt_ high
// OWNED | exactly one grant held by owner_q, kept while its mReq_ stays low
module bus_arbiter_mux #(
  parameter int N_MASTERS = 4,
  parameter int ADDR_W    = 30,
  parameter int DATA_W    = 32,
  parameter int REG_OUT   = 1,
  localparam int OW       = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1
) (
  input  logic                          clk,
  input  logic                          reset_,
  input  logic [N_MASTERS-1:0]          mReq_,
  input  logic [N_MASTERS*ADDR_W-1:0]   mAddr,
  input  logic [N_MASTERS-1:0]          mAs_,
  input  logic [N_MASTERS-1:0]          mRW,
  input  logic [N_MASTERS*DATA_W-1:0]   mData,
  output logic [N_MASTERS-1:0]          mGrnt_,
  output logic [ADDR_W-1:0]             sAddr,
  output logic                          sAs_,
  output logic                          sRW,
  output logic [DATA_W-1:0]             sData,
  output logic [OW-1:0]                 owner,
  output logic                          busy
);

  typedef enum logic {IDLE, OWNED} state_e;

  state_e               state_q, state_d;
  logic [N_MASTERS-1:0] grnt_q, grnt_d;
  logic [OW-1:0]        owner_q, owner_d;
  logic [OW-1:0]        rr_ptr_q, rr_ptr_d;

  logic                 win_found;
  logic [OW-1:0]        win_idx;
  logic                 owner_req_n;
  logic [ADDR_W-1:0]    s_addr_d;
  logic                 s_as_n_d;
  logic                 s_rw_d;
  logic [DATA_W-1:0]    s_data_d;

  // Search starts just after the last winner, so the previous owner comes last.
  always_comb begin : arb_search
    int idx;
    win_found = 1'b0;
    win_idx   = '0;
    idx       = 0;
    for (int k = 1; k <= N_MASTERS; k++) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= N_MASTERS) idx = idx - N_MASTERS;
      for (int i = 0; i < N_MASTERS; i++) begin
        if (!win_found && (i == idx) && !mReq_[i]) begin
          win_found = 1'b1;
          win_idx   = OW'(i);
        end
      end
    end
  end

  always_comb begin : owner_mux
    owner_req_n = 1'b1;
    s_addr_d    = '0;
    s_as_n_d    = 1'b1;
    s_rw_d      = 1'b1;
    s_data_d    = '0;
    for (int i = 0; i < N_MASTERS; i++) begin
      if (owner_q == OW'(i)) begin
        owner_req_n = mReq_[i];
        if (state_q == OWNED) begin
          s_addr_d = mAddr[i*ADDR_W +: ADDR_W];
          s_as_n_d = mAs_[i];
          s_rw_d   = mRW[i];
          s_data_d = mData[i*DATA_W +: DATA_W];
        end
      end
    end
  end

  always_comb begin : arb_next
    state_d  = state_q;
    grnt_d   = grnt_q;
    owner_d  = owner_q;
    rr_ptr_d = rr_ptr_q;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d          = OWNED;
          grnt_d           = '1;
          grnt_d[win_idx]  = 1'b0;
          owner_d          = win_idx;
          rr_ptr_d         = win_idx;
        end
      end
      OWNED: begin
        // Owner's own request is high here, so it can never be the winner.
        if (owner_req_n) begin
          if (win_found) begin
            grnt_d          = '1;
            grnt_d[win_idx] = 1'b0;
            owner_d         = win_idx;
            rr_ptr_d        = win_idx;
          end else begin
            state_d = IDLE;
            grnt_d  = '1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grnt_d  = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_) begin
    if (!reset_) begin
      state_q  <= IDLE;
      grnt_q   <= '1;
      owner_q  <= '0;
      rr_ptr_q <= OW'(N_MASTERS - 1);
    end else begin
      state_q  <= state_d;
      grnt_q   <= grnt_d;
      owner_q  <= owner_d;
      rr_ptr_q <= rr_ptr_d;
    end
  end

  assign mGrnt_ = grnt_q;
  assign owner  = owner_q;
  assign busy   = ~&grnt_q;

  generate
    if (REG_OUT != 0) begin : g_reg_out
      logic [ADDR_W-1:0] s_addr_q;
      logic              s_as_n_q;
      logic              s_rw_q;
      logic [DATA_W-1:0] s_data_q;

      always_ff @(posedge clk or negedge reset_) begin
        if (!reset_) begin
          s_addr_q <= '0;
          s_as_n_q <= 1'b1;
          s_rw_q   <= 1'b1;
          s_data_q <= '0;
        end else begin
          s_addr_q <= s_addr_d;
          s_as_n_q <= s_as_n_d;
          s_rw_q   <= s_rw_d;
          s_data_q <= s_data_d;
        end
      end

      assign sAddr = s_addr_q;
      assign sAs_  = s_as_n_q;
      assign sRW   = s_rw_q;
      assign sData = s_data_q;
    end else begin : g_comb_out
      assign sAddr = s_addr_d;
      assign sAs_  = s_as_n_d;
      assign sRW   = s_rw_d;
      assign sData = s_data_d;
    end
  endgenerate

endmodule

// File: tb/tb_bus_arbiter_mux.sv
// Bench for bus_arbiter_mux: 4-master instances with and without the output
// register, plus 2- and 5-master instances for rotation and wrap.
module tb_bus_arbiter_mux;
  localparam int AW = 30;
  localparam int DW = 32;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic              reset_;
  logic [3:0]        m_req_n, m_as_n, m_rw;
  logic [4*AW-1:0]   m_addr;
  logic [4*DW-1:0]   m_data;

  logic [3:0]        r_grnt, c_grnt;
  logic [AW-1:0]     r_addr, c_addr;
  logic              r_as, c_as, r_rw, c_rw, r_busy, c_busy;
  logic [DW-1:0]     r_data, c_data;
  logic [1:0]        r_owner, c_owner;

  logic [1:0]        req2, g2;
  logic [0:0]        o2;
  logic              b2, as2, rw2;
  logic [AW-1:0]     a2;
  logic [DW-1:0]     d2;
  logic [4:0]        req5, g5;
  logic [2:0]        o5;
  logic              b5, as5, rw5;
  logic [AW-1:0]     a5;
  logic [DW-1:0]     d5;

  bus_arbiter_mux #(.N_MASTERS(4), .ADDR_W(AW), .DATA_W(DW), .REG_OUT(1)) dut (
    .clk(clk), .reset_(reset_), .mReq_(m_req_n), .mAddr(m_addr), .mAs_(m_as_n),
    .mRW(m_rw), .mData(m_data), .mGrnt_(r_grnt), .sAddr(r_addr), .sAs_(r_as),
    .sRW(r_rw), .sData(r_data), .owner(r_owner), .busy(r_busy));

  bus_arbiter_mux #(.N_MASTERS(4), .ADDR_W(AW), .DATA_W(DW), .REG_OUT(0)) dut_c (
    .clk(clk), .reset_(reset_), .mReq_(m_req_n), .mAddr(m_addr), .mAs_(m_as_n),
    .mRW(m_rw), .mData(m_data), .mGrnt_(c_grnt), .sAddr(c_addr), .sAs_(c_as),
    .sRW(c_rw), .sData(c_data), .owner(c_owner), .busy(c_busy));

  bus_arbiter_mux #(.N_MASTERS(2), .ADDR_W(AW), .DATA_W(DW), .REG_OUT(1)) dut2 (
    .clk(clk), .reset_(reset_), .mReq_(req2), .mAddr({2*AW{1'b0}}), .mAs_(2'b11),
    .mRW(2'b11), .mData({2*DW{1'b0}}), .mGrnt_(g2), .sAddr(a2), .sAs_(as2),
    .sRW(rw2), .sData(d2), .owner(o2), .busy(b2));

  bus_arbiter_mux #(.N_MASTERS(5), .ADDR_W(AW), .DATA_W(DW), .REG_OUT(0)) dut5 (
    .clk(clk), .reset_(reset_), .mReq_(req5), .mAddr({5*AW{1'b0}}), .mAs_(5'b11111),
    .mRW(5'b11111), .mData({5*DW{1'b0}}), .mGrnt_(g5), .sAddr(a5), .sAs_(as5),
    .sRW(rw5), .sData(d5), .owner(o5), .busy(b5));

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          as_n;
    logic          rw;
    logic [DW-1:0] data;
  } slv_t;

  int   checks = 0;
  int   errors = 0;
  int   own_q[$];
  int   own2_q[$];
  slv_t slv_q[$];
  slv_t slv_idle;

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Grant exclusivity and busy consistency on every instance, every cycle.
  always @(negedge clk) begin
    checks++;
    if ($countones(~r_grnt) > 1 || $countones(~c_grnt) > 1 || $countones(~g2) > 1 ||
        $countones(~g5) > 1 || r_busy !== ~&r_grnt || c_busy !== ~&c_grnt ||
        b2 !== ~&g2 || b5 !== ~&g5) begin
      errors++;
      $display("FAIL grant_onehot: r=%b/%b c=%b/%b g2=%b/%b g5=%b/%b need <=1 low and busy==~&grnt",
               r_grnt, r_busy, c_grnt, c_busy, g2, b2, g5, b5);
    end
  end

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      cycle();
      checks++;
      if (r_grnt !== 4'hF || r_busy !== 1'b0 || r_owner !== 2'd0 || r_as !== 1'b1 ||
          r_rw !== 1'b1 || r_addr !== '0 || r_data !== '0 || c_grnt !== 4'hF || c_as !== 1'b1) begin
        errors++;
        $display("FAIL reset_state: grnt=%b busy=%b owner=%0d as=%b rw=%b addr=%h c_grnt=%b c_as=%b expected 1111/0/0/1/1/0",
                 r_grnt, r_busy, r_owner, r_as, r_rw, r_addr, c_grnt, c_as);
      end
    end
    reset_ = 1'b1;
  endtask

  task automatic test_round_robin();
    int exp_o;
    int prev;
    logic [3:0] exp_g;
    prev = 0;
    own_q.push_back(0); own_q.push_back(1); own_q.push_back(2);
    own_q.push_back(3); own_q.push_back(0);
    m_req_n = 4'b0000;
    for (int g = 0; g < 5; g++) begin
      cycle();
      exp_o = own_q.pop_front();
      exp_g = 4'hF;
      exp_g[exp_o] = 1'b0;
      checks++;
      if (r_owner !== 2'(exp_o) || r_grnt !== exp_g || r_busy !== 1'b1 || c_grnt !== exp_g) begin
        errors++;
        $display("FAIL rr_grant_%0d: owner=%0d grnt=%b c_grnt=%b expected owner=%0d grnt=%b",
                 g, r_owner, r_grnt, c_grnt, exp_o, exp_g);
      end
      if (g > 0) m_req_n[prev] = 1'b0;
      repeat (3) begin
        cycle();
        checks++;
        if (r_grnt !== exp_g) begin
          errors++;
          $display("FAIL rr_hold_%0d: grnt=%b expected %b", g, r_grnt, exp_g);
        end
      end
      m_req_n[exp_o] = 1'b1;
      prev = exp_o;
    end
    m_req_n = 4'b1111;
    cycle();
    checks++;
    if (r_grnt !== 4'hF || r_busy !== 1'b0 || c_grnt !== 4'hF) begin
      errors++;
      $display("FAIL rr_to_idle: grnt=%b busy=%b c_grnt=%b expected 1111/0", r_grnt, r_busy, c_grnt);
    end
  endtask

  task automatic test_no_preempt();
    int exp_o;
    own_q.push_back(2);
    own_q.push_back(3);
    m_req_n = 4'b1011;
    cycle();
    exp_o = own_q.pop_front();
    checks++;
    if (r_owner !== 2'(exp_o) || r_grnt !== 4'b1011) begin
      errors++;
      $display("FAIL np_first: owner=%0d grnt=%b expected owner=%0d grnt=1011", r_owner, r_grnt, exp_o);
    end
    m_req_n = 4'b0010;
    repeat (4) begin
      cycle();
      checks++;
      if (r_grnt !== 4'b1011 || r_owner !== 2'd2) begin
        errors++;
        $display("FAIL np_hold: owner=%0d grnt=%b expected owner=2 grnt=1011", r_owner, r_grnt);
      end
    end
    m_req_n = 4'b0110;
    cycle();
    exp_o = own_q.pop_front();
    checks++;
    if (r_owner !== 2'(exp_o) || r_grnt !== 4'b0111) begin
      errors++;
      $display("FAIL np_next: owner=%0d grnt=%b expected owner=%0d grnt=0111", r_owner, r_grnt, exp_o);
    end
    m_req_n = 4'b1111;
    cycle();
    checks++;
    if (r_grnt !== 4'hF || r_busy !== 1'b0) begin
      errors++;
      $display("FAIL np_idle: grnt=%b busy=%b expected 1111/0", r_grnt, r_busy);
    end
  endtask

  task automatic test_mux();
    slv_t e;
    m_as_n[0] = 1'b0;
    m_rw[0]   = 1'b0;
    m_addr[0 +: AW] = 30'h3FF_0000;
    m_data[0 +: DW] = 32'h1111_1111;
    m_req_n = 4'b1101;
    cycle();
    checks++;
    if (r_grnt !== 4'b1101) begin
      errors++;
      $display("FAIL mux_grant: grnt=%b expected 1101", r_grnt);
    end
    m_addr[AW +: AW] = 30'h0000_1234;
    m_as_n[1] = 1'b0;
    m_rw[1]   = 1'b0;
    m_data[DW +: DW] = 32'hDEAD_BEEF;
    slv_q.push_back(slv_t'{30'h0000_1234, 1'b0, 1'b0, 32'hDEAD_BEEF});
    #1;
    e = slv_q[0];
    checks++;
    if ({c_addr, c_as, c_rw, c_data} !== e) begin
      errors++;
      $display("FAIL mux_comb_1: got %h/%b/%b/%h expected %h/%b/%b/%h",
               c_addr, c_as, c_rw, c_data, e.addr, e.as_n, e.rw, e.data);
    end
    checks++;
    if ({r_addr, r_as, r_rw, r_data} !== slv_idle) begin
      errors++;
      $display("FAIL mux_reg_lag: got %h/%b/%b/%h expected idle 0/1/1/0", r_addr, r_as, r_rw, r_data);
    end
    cycle();
    e = slv_q.pop_front();
    checks++;
    if ({r_addr, r_as, r_rw, r_data} !== e) begin
      errors++;
      $display("FAIL mux_reg_1: got %h/%b/%b/%h expected %h/%b/%b/%h",
               r_addr, r_as, r_rw, r_data, e.addr, e.as_n, e.rw, e.data);
    end
    m_addr[AW +: AW] = 30'h2ABC_DEF0;
    m_as_n[1] = 1'b1;
    m_rw[1]   = 1'b1;
    m_data[DW +: DW] = 32'hCAFE_F00D;
    slv_q.push_back(slv_t'{30'h2ABC_DEF0, 1'b1, 1'b1, 32'hCAFE_F00D});
    #1;
    e = slv_q[0];
    checks++;
    if ({c_addr, c_as, c_rw, c_data} !== e) begin
      errors++;
      $display("FAIL mux_comb_2: got %h/%b/%b/%h expected %h/%b/%b/%h",
               c_addr, c_as, c_rw, c_data, e.addr, e.as_n, e.rw, e.data);
    end
    cycle();
    e = slv_q.pop_front();
    checks++;
    if ({r_addr, r_as, r_rw, r_data} !== e) begin
      errors++;
      $display("FAIL mux_reg_2: got %h/%b/%b/%h expected %h/%b/%b/%h",
               r_addr, r_as, r_rw, r_data, e.addr, e.as_n, e.rw, e.data);
    end
    m_req_n = 4'b1111;
    cycle();
    checks++;
    if (c_grnt !== 4'hF || {c_addr, c_as, c_rw, c_data} !== slv_idle) begin
      errors++;
      $display("FAIL mux_comb_idle: grnt=%b got %h/%b/%b/%h expected 1111 0/1/1/0",
               c_grnt, c_addr, c_as, c_rw, c_data);
    end
    cycle();
    checks++;
    if ({r_addr, r_as, r_rw, r_data} !== slv_idle) begin
      errors++;
      $display("FAIL mux_reg_idle: got %h/%b/%b/%h expected 0/1/1/0", r_addr, r_as, r_rw, r_data);
    end
    m_as_n = 4'b1111;
    m_rw   = 4'b1111;
    m_addr = '0;
    m_data = '0;
  endtask

  task automatic test_async_reset();
    int exp_o;
    m_req_n = 4'b0111;
    cycle();
    checks++;
    if (r_owner !== 2'd3 || r_grnt !== 4'b0111) begin
      errors++;
      $display("FAIL ar_own: owner=%0d grnt=%b expected 3/0111", r_owner, r_grnt);
    end
    m_as_n[3] = 1'b0;
    m_addr[3*AW +: AW] = 30'h55;
    cycle();
    checks++;
    if (r_as !== 1'b0 || r_addr !== 30'h55) begin
      errors++;
      $display("FAIL ar_strobe: as=%b addr=%h expected 0/55", r_as, r_addr);
    end
    #3;
    reset_ = 1'b0;
    #1;
    checks++;
    if (r_grnt !== 4'hF || r_as !== 1'b1 || r_busy !== 1'b0 || c_grnt !== 4'hF || c_as !== 1'b1) begin
      errors++;
      $display("FAIL ar_immediate: grnt=%b as=%b busy=%b c_grnt=%b c_as=%b expected 1111/1/0/1111/1",
               r_grnt, r_as, r_busy, c_grnt, c_as);
    end
    m_req_n = 4'b0000;
    m_as_n  = 4'b1111;
    m_addr  = '0;
    cycle();
    reset_ = 1'b1;
    own_q.push_back(0);
    cycle();
    exp_o = own_q.pop_front();
    checks++;
    if (r_owner !== 2'(exp_o) || r_grnt !== 4'b1110) begin
      errors++;
      $display("FAIL ar_first: owner=%0d grnt=%b expected owner=%0d grnt=1110", r_owner, r_grnt, exp_o);
    end
    m_req_n = 4'b1111;
    cycle();
    checks++;
    if (r_grnt !== 4'hF || r_busy !== 1'b0) begin
      errors++;
      $display("FAIL ar_idle: grnt=%b busy=%b expected 1111/0", r_grnt, r_busy);
    end
  endtask

  task automatic test_rotate();
    int e2, e5;
    logic [1:0] x2;
    logic [4:0] x5;
    for (int i = 0; i < 7; i++) begin
      own2_q.push_back(i % 2);
      own_q.push_back(i % 5);
    end
    req2 = 2'b00;
    req5 = 5'b00000;
    for (int i = 0; i < 7; i++) begin
      cycle();
      e2 = own2_q.pop_front();
      e5 = own_q.pop_front();
      x2 = 2'b11;
      x2[e2] = 1'b0;
      x5 = 5'h1F;
      x5[e5] = 1'b0;
      checks++;
      if (o2 !== 1'(e2) || g2 !== x2) begin
        errors++;
        $display("FAIL rot2_%0d: owner=%0d grnt=%b expected owner=%0d grnt=%b", i, o2, g2, e2, x2);
      end
      checks++;
      if (o5 !== 3'(e5) || g5 !== x5) begin
        errors++;
        $display("FAIL rot5_%0d: owner=%0d grnt=%b expected owner=%0d grnt=%b", i, o5, g5, e5, x5);
      end
      req2 = 2'b00;
      req2[e2] = 1'b1;
      req5 = 5'b00000;
      req5[e5] = 1'b1;
    end
    req2 = 2'b11;
    req5 = 5'h1F;
    cycle();
    checks++;
    if (g2 !== 2'b11 || g5 !== 5'h1F || b2 !== 1'b0 || b5 !== 1'b0) begin
      errors++;
      $display("FAIL rot_idle: g2=%b g5=%b b2=%b b5=%b expected all high, not busy", g2, g5, b2, b5);
    end
  endtask

  initial begin
    slv_idle = slv_t'{{AW{1'b0}}, 1'b1, 1'b1, {DW{1'b0}}};
    reset_  = 1'b0;
    m_req_n = 4'b1111;
    m_as_n  = 4'b1111;
    m_rw    = 4'b1111;
    m_addr  = '0;
    m_data  = '0;
    req2    = 2'b11;
    req5    = 5'h1F;
    test_reset();
    test_round_robin();
    test_no_preempt();
    test_mux();
    test_async_reset();
    test_rotate();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
